// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode display sharing one 7-segment decoder.
// Frame-synchronous load path keeps every frame showing a single consistent value.
module seg_scan_ctrl #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic        load,
  output logic        load_ack,
  output logic        pending,
  input  logic        lz_blank,
  output logic [3:0]  dec_in,
  input  logic [6:0]  dec_out,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = $clog2(DIGITS);

  localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntOn   = CntW'(BLANK_CYCLES);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);

  typedef enum logic [0:0] {StGuard, StOn} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [15:0]     display_q, display_d;
  logic [15:0]     staging_q, staging_d;
  logic            pending_q, pending_d;
  logic            ack_q, ack_d;
  logic            tick_q;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            tc;
  logic            boundary;
  logic            lead_zero;

  assign tc       = (cnt_q == CntLast);
  assign boundary = tc && (idx_q == IdxLast);

  // Slot counter and digit index
  always_comb begin
    cnt_d = tc ? '0 : cnt_q + 1'b1;
    idx_d = tc ? idx_q + 1'b1 : idx_q;
  end

  // Digit-slot FSM: guard cycles with anodes off, then the digit is lit
  always_comb begin
    state_d = state_q;
    case (state_q)
      StGuard: if (!tc && (cnt_d >= CntOn)) state_d = StOn;
      StOn:    if (tc) state_d = StGuard;
      default: state_d = StGuard;
    endcase
  end

  // Digit k blanks when it and every more-significant nibble are zero; digit 0 never blanks
  always_comb begin
    lead_zero = 1'b0;
    case (idx_q)
      2'd1:    lead_zero = (display_q[15:4] == '0);
      2'd2:    lead_zero = (display_q[15:8] == '0);
      2'd3:    lead_zero = (display_q[15:12] == '0);
      default: lead_zero = 1'b0;
    endcase
    lead_zero = lead_zero & lz_blank;
  end

  // A lit slot never spans a TC edge, so idx_q is already the index of the slot being lit
  always_comb begin
    an_d  = (state_d == StOn) ? ~(4'b0001 << idx_q) : 4'b1111;
    seg_d = ((state_d == StOn) && !lead_zero) ? dec_out : 7'b1111111;
  end

  // Load handshake: stage mid-frame, commit only at the frame boundary
  always_comb begin
    display_d = display_q;
    staging_d = staging_q;
    pending_d = pending_q;
    ack_d     = 1'b0;
    if (boundary) begin
      if (load) begin
        display_d = value_in;
      end else if (pending_q) begin
        display_d = staging_q;
      end
      ack_d     = load | pending_q;
      pending_d = 1'b0;
    end else if (load) begin
      staging_d = value_in;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StGuard;
      cnt_q     <= '0;
      idx_q     <= '0;
      display_q <= '0;
      staging_q <= '0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      tick_q    <= 1'b0;
      an_q      <= 4'b1111;
      seg_q     <= 7'b1111111;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      display_q <= display_d;
      staging_q <= staging_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      tick_q    <= boundary;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign dec_in     = display_q[{idx_q, 2'b00} +: 4];
  assign load_ack   = ack_q;
  assign pending    = pending_q;
  assign frame_tick = tick_q;
  assign an         = an_q;
  assign seg        = seg_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexes one shared 4-bit to 7-segment Decoder across a 4-digit common-anode display for the Timer project.
- Sequences the digit index and anode strobes, and feeds each nibble to the Decoder.
- Registers the Decoder output onto the segment bus.
- Provides frame-synchronous value loading so a display update never tears mid-frame.

Parameters:
- DIGITS, 4, number of digits scanned; fixed at 4 for this revision.
- SCAN_DIV, 50000, clock cycles per digit slot; must be at least BLANK_CYCLES+2.
- BLANK_CYCLES, 2, anti-ghosting guard cycles at the start of each slot with all anodes off.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- value_in  in  16  four nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3
- load  in  1  one-cycle request to display value_in
- load_ack  out  1  one-cycle pulse when a loaded value becomes the displayed value
- pending  out  1  a staged value is waiting for the frame boundary
- lz_blank  in  1  enables leading-zero blanking
- dec_in  out  4  nibble driven to the shared Decoder
- dec_out  in  7  Decoder segment pattern, active-low
- seg  out  7  segment bus, active-low; 7'b1111111 is blank
- an  out  4  anode selects, active-low; an[i] drives digit i
- frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) sets: slot counter cnt=0, digit index idx=0, display=0, staging=0, pending=0, load_ack=0, frame_tick=0, an=4'b1111, seg=7'b1111111.
- Reset mid-slot or mid-load discards the staged value, and no ack is issued.
- Slot counter:
  - cnt counts 0..SCAN_DIV-1.
  - At terminal count (TC), cnt returns to 0 and idx increments, wrapping from 3 to 0.
- Frame boundary is TC with idx==3. frame_tick=1 on the cycle after the boundary, aligned with idx=0, cnt=0.
- dec_in = display nibble[idx], combinational from registered idx and display. The Decoder is combinational.
- Digit-slot state machine: states GUARD and ON.
  - GUARD, while cnt < BLANK_CYCLES: an=4'b1111.
  - ON, for the rest of the slot: an = ~(1<<idx).
  - Transition GUARD to ON when cnt reaches BLANK_CYCLES; ON to GUARD at TC.
- an and seg are registered. seg <= dec_out, or 7'b1111111 when blanked. Both update on the same edge, so seg and an are always aligned to the same idx.
- Latency: a value change on display appears on seg exactly 1 cycle later within an ON slot.
- Leading-zero blanking, when lz_blank=1:
  - Digit k is blanked if nibbles k..3 are all zero, for k = 1..3.
  - Digit 0 is never blanked, so a value of 0 shows "0".
  - Blanking sets seg=7'b1111111; an still strobes normally.
- Nibbles 10..15 are passed to the Decoder unchanged; no clamping.
- Load handshake:
  - load=1, not at a boundary: staging <= value_in, pending <= 1.
  - load while already pending: overwrite staging (last wins); no extra ack.
  - Boundary with pending=1: display <= staging, pending <= 0, load_ack=1 for one cycle, coincident with frame_tick.
  - load on the boundary cycle itself: value_in goes directly to display (bypassing staging), pending <= 0, load_ack=1 on the next cycle.
  - Boundary with no pending value and no load: display is unchanged, no ack.
- display only ever changes at a boundary; a frame never mixes old and new digits.

Test Plan (SCAN_DIV=8, BLANK_CYCLES=2):
- Reset hold 3 cycles, release -> an=1111, seg=1111111 through cnt=0..1; cnt=2 -> an=1110, seg=dec_out(0), dec_in=0.
- load value_in=16'h1234 mid-frame -> pending=1 immediately; at next boundary display=1234, load_ack and frame_tick both pulse 1 cycle. Next frame: dec_in 4,3,2,1 with an 1110, 1101, 1011, 0111, each ON for 6 cycles.
- Two loads in one frame (16'h1111, then 16'h2222) -> single load_ack; displayed value 2222.
- load 16'h5678 asserted exactly on the boundary cycle -> display=5678 on the next cycle; load_ack 1 cycle; pending stays 0.
- lz_blank=1 with value 16'h0070:
  - digits 3 and 2 -> seg=1111111;
  - digit 1 -> dec_out(7);
  - digit 0 -> dec_out(0).
  - With value 16'h0000, only digit 0 shows.
- rst asserted while pending=1 mid-frame -> pending=0, no load_ack, display=0, idx=0 on the next cycle.
